// File: rtl/tt_um_karthik_serial_add_ctrl.sv
// Bit-serial 4-bit unsigned adder with start/ack handshake.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   ena           : power-good, ignored
//   ui_in[3:0]    : operand A, ui_in[7:4] operand B (sampled on capture)
//   uio_in[0]     : start request (edge-detected), uio_in[1] ack
//   uo_out        : {missed_start, done, busy, result[4:0]}
//   uio_out       : {state[1:0], bit_index[1:0], 4'b0}
//   uio_oe        : constant 8'hF0
module tt_um_karthik_serial_add_ctrl (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = OP_W + 1;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t             state_q, state_n;
  logic               start_q;
  logic               armed_q;
  logic [OP_W-1:0]    a_sr_q, b_sr_q, psum_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [RES_W-1:0]   result_q;
  logic               busy_q, done_q, miss_q;

  logic start_edge_c, ack_c, last_c;
  logic load_c, step_c, set_miss_c, clr_miss_c;
  logic ha1_s_c, ha1_c_c, sum_c, ha2_c_c, carry_n_c;

  // Unused inputs kept referenced so they are not flagged.
  logic unused_in;
  assign unused_in = &{1'b0, ena, uio_in[7:2]};

  // armed_q masks the first edge after reset release so a held start is not an edge.
  assign start_edge_c = uio_in[0] & ~start_q & armed_q;
  assign ack_c        = uio_in[1];
  assign last_c       = (idx_q == IDX_W'(OP_W - 1));

  // Full-add cell: two cascaded half adders.
  assign ha1_s_c   = a_sr_q[0] ^ b_sr_q[0];
  assign ha1_c_c   = a_sr_q[0] & b_sr_q[0];
  assign sum_c     = ha1_s_c ^ carry_q;
  assign ha2_c_c   = ha1_s_c & carry_q;
  assign carry_n_c = ha1_c_c | ha2_c_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (start_edge_c) state_n = ST_RUN;
      ST_RUN:  if (last_c)       state_n = ST_DONE;
      ST_DONE: if (ack_c)        state_n = ST_IDLE;
      default:                   state_n = ST_IDLE;
    endcase
  end

  // Control strobes; in DONE an ack beats a coincident start.
  always_comb begin
    load_c     = 1'b0;
    step_c     = 1'b0;
    set_miss_c = 1'b0;
    clr_miss_c = 1'b0;
    case (state_q)
      ST_IDLE: load_c = start_edge_c;
      ST_RUN: begin
        step_c     = 1'b1;
        set_miss_c = start_edge_c;
      end
      ST_DONE: begin
        clr_miss_c = ack_c;
        set_miss_c = start_edge_c & ~ack_c;
      end
      default: ;
    endcase
  end

  // Datapath and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      start_q <= uio_in[0];
      armed_q <= 1'b1;
      busy_q  <= (state_n == ST_RUN);
      done_q  <= (state_n == ST_DONE);
      if (load_c) begin
        a_sr_q  <= ui_in[OP_W-1:0];
        b_sr_q  <= ui_in[2*OP_W-1:OP_W];
        psum_q  <= '0;
        carry_q <= 1'b0;
        idx_q   <= '0;
      end else if (step_c) begin
        a_sr_q  <= {1'b0, a_sr_q[OP_W-1:1]};
        b_sr_q  <= {1'b0, b_sr_q[OP_W-1:1]};
        psum_q  <= {sum_c, psum_q[OP_W-1:1]};
        carry_q <= carry_n_c;
        idx_q   <= idx_q + IDX_W'(1);
        if (last_c) result_q <= {carry_n_c, sum_c, psum_q[OP_W-1:1]};
      end
      if (clr_miss_c)      miss_q <= 1'b0;
      else if (set_miss_c) miss_q <= 1'b1;
    end
  end

  assign uo_out  = {miss_q, done_q, busy_q, result_q};
  assign uio_out = {state_q, idx_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_karthik_serial_add_ctrl.sv
// Directed bench for the bit-serial adder controller.
module tb_tt_um_karthik_serial_add_ctrl;

  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       ena, clk, rst_n;
  int         n_vec, n_bad;

  tt_um_karthik_serial_add_ctrl dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Capture A/B, check 4 busy cycles with held previous result, then done.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] prev, input logic [4:0] exp, input bit poke);
    @(negedge clk);
    ui_in     = {b, a};
    uio_in[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("busy%0d", k), {26'd0, uo_out[5:0]}, {26'd0, 1'b1, prev});
      chk($sformatf("stidx%0d", k), {24'd0, uio_out}, {24'd0, 2'b01, 2'(k), 4'b0});
      uio_in[0] = poke && (k == 1);
      if (poke && k == 1) ui_in = 8'hFF;
    end
    @(negedge clk);
    chk("done", {24'd0, uo_out}, {24'd0, poke, 2'b10, exp});
    chk("st_done", {24'd0, uio_out}, 32'h80);
  endtask

  task automatic do_ack(input logic [7:0] exp_uo);
    @(negedge clk);
    uio_in[1] = 1'b1;
    @(negedge clk);
    uio_in[1] = 1'b0;
    chk("ack_uo", {24'd0, uo_out}, {24'd0, exp_uo});
    chk("ack_st", {24'd0, uio_out}, 32'h00);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    #1;
    chk("rst_uo", {24'd0, uo_out}, 32'h00);
    chk("rst_uio", {24'd0, uio_out}, 32'h00);
    chk("rst_oe", {24'd0, uio_oe}, 32'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(4'd9, 4'd7, 5'd0, 5'b10000, 1'b0);
    do_ack(8'h10);
    // Ack in IDLE does nothing.
    do_ack(8'h10);

    run_op(4'd15, 4'd15, 5'd16, 5'b11110, 1'b0);
    do_ack(8'h1E);
    run_op(4'd0, 4'd0, 5'd30, 5'b00000, 1'b0);
    do_ack(8'h00);

    // Second start mid-run plus operand change must not disturb the sum.
    run_op(4'd3, 4'd4, 5'd0, 5'b00111, 1'b1);
    @(negedge clk);
    chk("miss_hold", {24'd0, uo_out}, 32'hC7);
    do_ack(8'h07);

    // Reset at RUN index 2.
    @(negedge clk);
    ui_in     = 8'h65;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_idx2", {24'd0, uio_out}, 32'h60);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uo", {24'd0, uo_out}, 32'h00);
    chk("arst_uio", {24'd0, uio_out}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_uo", {24'd0, uo_out}, 32'h00);
    chk("post_rst_st", {24'd0, uio_out}, 32'h00);

    // Start edge in DONE sets missed flag; ack+start together clears it, no capture.
    run_op(4'd1, 4'd2, 5'd0, 5'b00011, 1'b0);
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    chk("done_miss", {24'd0, uo_out}, 32'hC3);
    @(negedge clk);
    ui_in     = 8'hFF;
    uio_in    = 8'h03;
    @(negedge clk);
    uio_in[1] = 1'b0;
    chk("ackwin_uo", {24'd0, uo_out}, 32'h03);
    chk("ackwin_st", {24'd0, uio_out}, 32'h00);
    repeat (3) @(negedge clk);
    chk("held_start", {24'd0, uo_out}, 32'h03);
    chk("held_st", {24'd0, uio_out}, 32'h00);

    // Start held high through reset release.
    rst_n = 1'b0;
    @(negedge clk);
    chk("oe_rst", {24'd0, uio_oe}, 32'hF0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rel_uo", {24'd0, uo_out}, 32'h00);
    chk("rel_st", {24'd0, uio_out}, 32'h00);
    chk("rel_oe", {24'd0, uio_oe}, 32'hF0);
    uio_in[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_karthik_serial_add_ctrl.md
TT_UM_KARTHIK_SERIAL_ADD_CTRL -- requirements
Module: tt_um_karthik_serial_add_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 clk  input  1  the single clock; all state SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  always 1 when powered; the block SHALL ignore it.
REQ-005 ui_in  input  8  [3:0] operand A, [7:4] operand B; both sampled only on a start capture.
REQ-006 uio_in  input  8  [0] start request, [1] ack; [7:2] unused.
REQ-007 uo_out  output  8  [4:0] result register, [5] busy, [6] done, [7] missed-start flag.
REQ-008 uio_out  output  8  [7:6] state code, [5:4] bit index; [3:0] SHALL be 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'hF0.

Function
REQ-010 The block SHALL add A+B bit-serially, LSB first, one bit per clock, using one full-add cell built from two cascaded half adders plus a carry register.
REQ-011 The FSM SHALL have states IDLE (code 00), RUN (01) and DONE (10); code 11 SHALL be unreachable and SHALL return to IDLE.
REQ-012 start_q SHALL be a register of uio_in[0]; a start edge is uio_in[0]=1 with start_q=0.
REQ-013 In IDLE, on a start edge the block SHALL load A and B into shift registers, clear the carry and the bit index, and enter RUN.
REQ-014 In RUN, each cycle SHALL compute sum = a0^b0^c and carry' = (a0&b0)|(c&(a0^b0)). The sum bit SHALL shift into a partial-sum register, the operands SHALL shift right, and the index SHALL increment.
REQ-015 On the RUN cycle with index 3, the block SHALL write {carry', partial sum[3:0]} to the result register and enter DONE. Result and done SHALL be visible 4 clocks after the capture edge.
REQ-016 The result register SHALL change only on RUN completion or reset. During RUN and IDLE, uo_out[4:0] SHALL hold the previous result.
REQ-017 busy (uo_out[5]) SHALL be 1 exactly while in RUN. done (uo_out[6]) SHALL be 1 exactly while in DONE.
REQ-018 In DONE, uio_in[1]=1 SHALL return the FSM to IDLE on the next edge; the result SHALL be held.
REQ-019 In DONE, start edges SHALL be ignored. If ack and a start edge coincide, ack SHALL win and no capture SHALL occur; a start held high SHALL NOT re-trigger.
REQ-020 A start edge in RUN or DONE SHALL set the sticky missed-start flag uo_out[7]. The flag SHALL clear only on an ack taken in DONE or on reset.
REQ-021 A start edge in RUN SHALL NOT disturb operands, index, carry or latency.
REQ-022 Ack in IDLE or RUN SHALL have no effect.
REQ-023 The arithmetic SHALL be unsigned and the result SHALL be 5 bits wide; max 15+15 = 30 SHALL NOT wrap.
REQ-024 All outputs SHALL be driven directly from registers or constants; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, regardless of clk:
- state to IDLE;
- result, shift registers, carry, index, start_q and missed-start flag to 0;
- uo_out to 8'h00;
- uio_out to 8'h00.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no result written. After release, the block SHALL need a fresh start edge.
REQ-027 Release of rst_n with uio_in[0] already high SHALL NOT count as a start edge (start_q was 0, but the first edge after release SHALL only load start_q).

Verification
REQ-028 A=9, B=7, pulse start -> busy for 4 clocks, then done=1, uo_out[4:0]=5'b10000; ack -> IDLE, result held.
REQ-029 A=15, B=15 -> uo_out[4:0]=5'b11110 after 4 RUN clocks; A=0, B=0 -> 5'b00000 with done=1.
REQ-030 Second start edge during RUN (A=3, B=4) -> result 5'b00111 on schedule, uo_out[7]=1 until ack.
REQ-031 rst_n low at RUN index 2 -> uo_out=8'h00 asynchronously; after release, IDLE with no result until a new start.
REQ-032 In DONE, assert ack and a new start edge on the same edge -> IDLE, no capture, result unchanged, uo_out[7]=0.
REQ-033 Hold start high through reset release -> no operation begins; uio_oe reads 8'hF0 throughout.
